// File: rtl/dpram_port_arbiter_pkg.sv
// Shared definitions for the DPRAM port-1 arbiter: default geometry, FSM
// state encoding and owner encoding.
package dpram_arb_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 18;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_CAPT  = 2'd3
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Client-side bundle of the arbiter: two independent req/ack requesters.
// The master modport is the client view, the slave modport the arbiter view.
interface dpram_port_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_b;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  ack_a, rdata_a,
    input  ack_b, rdata_b
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output ack_a, rdata_a,
    output ack_b, rdata_b
  );

endinterface

// File: rtl/dpram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone eligible requester wins outright, a tie
// goes to whichever requester was not granted last.
module rr_arbiter2
  import dpram_arb_pkg::*;
(
  input  logic eligible_a,
  input  logic eligible_b,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);

  always_comb begin
    grant_a = eligible_a && (!eligible_b || (last_grant == OWN_B));
    grant_b = eligible_b && (!eligible_a || (last_grant == OWN_A));
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares DPRAM port 1 between requesters A and B with a round-robin req/ack
// handshake, optionally zero-filling the RAM after reset.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
)(
  input  logic                 clock,
  input  logic                 reset,
  dpram_port_arbiter_if.slave  cli,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic                 init_done
);

  state_e            state_q,      state_d;
  logic [ADDR_W:0]   cnt_q,        cnt_d;
  logic              owner_q,      owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
  logic              ram_we_q,     ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
  logic              ack_a_q,      ack_a_d;
  logic              ack_b_q,      ack_b_d;
  logic [DATA_W-1:0] rdata_a_q,    rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q,    rdata_b_d;
  logic              init_done_q,  init_done_d;

  logic eligible_a, eligible_b;
  logic grant_a, grant_b;

  // A requester is masked during its own ack cycle so a held req is not re-served.
  assign eligible_a = cli.req_a && !ack_a_q;
  assign eligible_b = cli.req_b && !ack_b_q;

  rr_arbiter2 u_rr (
    .eligible_a (eligible_a),
    .eligible_b (eligible_b),
    .last_grant (last_grant_q),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state_q <= S_CLEAR;
      else                state_q <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_A;
      last_grant_q <= OWN_B;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      init_done_q  <= !CLEAR_ON_RESET;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      init_done_q  <= init_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    init_done_d  = init_done_q;

    case (state_q)
      // The extra counter bit marks the cycle after the last address has been issued.
      S_CLEAR: begin
        if (!cnt_q[ADDR_W]) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = cnt_q[ADDR_W-1:0];
          ram_wdata_d = '0;
          cnt_d       = cnt_q + 1'b1;
        end else begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (grant_a) begin
          owner_d      = OWN_A;
          last_grant_d = OWN_A;
          ram_addr_d   = cli.addr_a;
          ram_we_d     = cli.we_a;
          ram_wdata_d  = cli.wdata_a;
          state_d      = S_ISSUE;
        end else if (grant_b) begin
          owner_d      = OWN_B;
          last_grant_d = OWN_B;
          ram_addr_d   = cli.addr_b;
          ram_we_d     = cli.we_b;
          ram_wdata_d  = cli.wdata_b;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        if (owner_q == OWN_A) begin
          ack_a_d   = 1'b1;
          rdata_a_d = ram_rdata;
        end else begin
          ack_b_d   = 1'b1;
          rdata_b_d = ram_rdata;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign init_done   = init_done_q;
  assign cli.ack_a   = ack_a_q;
  assign cli.ack_b   = ack_b_q;
  assign cli.rdata_a = rdata_a_q;
  assign cli.rdata_b = rdata_b_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 128x18 dual-port RAM
// attached to port 1 and a read-only port 2 used to inspect RAM contents.
module tb_dpram_port_arbiter;
  import dpram_arb_pkg::*;

  localparam int AW    = 7;
  localparam int DW    = 18;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          init_done;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr2 = '0;
  logic [DW-1:0] dout2;

  int tests = 0;
  int fails = 0;

  dpram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cli ();

  dpram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .cli       (cli),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .init_done (init_done)
  );

  always #5 clock = ~clock;

  // Synchronous DPRAM: port 1 read/write, port 2 read-only.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    dout2     <= mem[addr2];
  end

  // Request fields must stay stable while req is held and not yet acked.
  logic          pa_req = 1'b0, pa_ack = 1'b0, pa_we = 1'b0;
  logic          pb_req = 1'b0, pb_ack = 1'b0, pb_we = 1'b0;
  logic [AW-1:0] pa_addr = '0, pb_addr = '0;
  logic [DW-1:0] pa_wd = '0, pb_wd = '0;
  always @(posedge clock) begin
    if (pa_req && !pa_ack && cli.req_a)
      assert (cli.addr_a == pa_addr && cli.we_a == pa_we && cli.wdata_a == pa_wd)
        else $error("requester A changed its request before ack");
    if (pb_req && !pb_ack && cli.req_b)
      assert (cli.addr_b == pb_addr && cli.we_b == pb_we && cli.wdata_b == pb_wd)
        else $error("requester B changed its request before ack");
    pa_req <= cli.req_a; pa_ack <= cli.ack_a; pa_we <= cli.we_a;
    pa_addr <= cli.addr_a; pa_wd <= cli.wdata_a;
    pb_req <= cli.req_b; pb_ack <= cli.ack_b; pb_we <= cli.we_b;
    pb_addr <= cli.addr_b; pb_wd <= cli.wdata_b;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit is_b, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (is_b) begin
      cli.req_b = r; cli.we_b = w; cli.addr_b = a; cli.wdata_b = d;
    end else begin
      cli.req_a = r; cli.we_a = w; cli.addr_a = a; cli.wdata_a = d;
    end
  endtask

  task automatic run_sweep(output int nwr, output int bad, output int last_at, output int done_at);
    nwr = 0; bad = 0; last_at = -1; done_at = -1;
    for (int c = 0; c < 400 && done_at < 0; c++) begin
      tick();
      if (ram_we) begin
        if (ram_addr !== AW'(nwr) || ram_wdata !== '0) bad++;
        if (last_at >= 0 && last_at != c - 1) bad++;
        nwr++;
        last_at = c;
      end
      if (cli.ack_a || cli.ack_b) bad++;
      if (init_done) done_at = c;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      fails++; $display("FAIL rst_port: we=%b addr=%0d wdata=%h, want 0/0/0", ram_we, ram_addr, ram_wdata);
    end
    tests++;
    if (cli.ack_a !== 1'b0 || cli.ack_b !== 1'b0 || cli.rdata_a !== '0 || cli.rdata_b !== '0) begin
      fails++; $display("FAIL rst_client: ack=%b%b rdata=%h/%h, want 00 0/0", cli.ack_a, cli.ack_b, cli.rdata_a, cli.rdata_b);
    end
    tests++;
    if (init_done !== 1'b0) begin
      fails++; $display("FAIL rst_init_done: got %b, want 0", init_done);
    end
  endtask

  task automatic test_clear();
    int nwr, bad, last_at, done_at;
    reset = 1'b0;
    run_sweep(nwr, bad, last_at, done_at);
    tests++;
    if (nwr !== 128) begin fails++; $display("FAIL clear_count: got %0d writes, want 128", nwr); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL clear_pattern: %0d bad cycles, want 0", bad); end
    tests++;
    if (done_at !== last_at + 1) begin
      fails++; $display("FAIL clear_done_time: init_done at %0d, want %0d", done_at, last_at + 1);
    end
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 7'd5, 18'h2AAAA);
    tick();
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 7'd5 || ram_wdata !== 18'h2AAAA) begin
      fails++; $display("FAIL wr_issue: we=%b addr=%0d wdata=%h, want 1/5/2aaaa", ram_we, ram_addr, ram_wdata);
    end
    tick();
    tests++;
    if (ram_we !== 1'b0 || cli.ack_a !== 1'b0) begin
      fails++; $display("FAIL wr_capt: we=%b ack_a=%b, want 0/0", ram_we, cli.ack_a);
    end
    tick();
    tests++;
    if (cli.ack_a !== 1'b1) begin fails++; $display("FAIL wr_ack_latency: ack_a=%b, want 1", cli.ack_a); end
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    tests++;
    if (cli.ack_a !== 1'b0) begin fails++; $display("FAIL ack_pulse: ack_a=%b, want 0", cli.ack_a); end
    set_req(0, 1'b1, 1'b0, 7'd5, '0);
    tick(); tick(); tick();
    tests++;
    if (cli.ack_a !== 1'b1 || cli.rdata_a !== 18'h2AAAA) begin
      fails++; $display("FAIL rd_addr5: ack_a=%b rdata_a=%h, want 1/2aaaa", cli.ack_a, cli.rdata_a);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    tests++;
    if (cli.ack_a !== 1'b0 || cli.rdata_a !== 18'h2AAAA) begin
      fails++; $display("FAIL rd_hold: ack_a=%b rdata_a=%h, want 0/2aaaa", cli.ack_a, cli.rdata_a);
    end
  endtask

  task automatic test_tie();
    set_req(1, 1'b1, 1'b1, 7'd6, 18'h12345);
    tick(); tick(); tick();
    tests++;
    if (cli.ack_b !== 1'b1) begin fails++; $display("FAIL b_wr_ack: ack_b=%b, want 1", cli.ack_b); end
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    set_req(0, 1'b1, 1'b0, 7'd5, '0);
    set_req(1, 1'b1, 1'b0, 7'd6, '0);
    tick();
    tests++;
    if (ram_addr !== 7'd5) begin fails++; $display("FAIL tie_first: ram_addr=%0d, want 5", ram_addr); end
    tick(); tick();
    tests++;
    if (cli.ack_a !== 1'b1 || cli.ack_b !== 1'b0 || cli.rdata_a !== 18'h2AAAA) begin
      fails++; $display("FAIL tie_ack_a: ack=%b%b rdata_a=%h, want a=1 b=0 2aaaa", cli.ack_a, cli.ack_b, cli.rdata_a);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    tests++;
    if (ram_addr !== 7'd6) begin fails++; $display("FAIL tie_second: ram_addr=%0d, want 6", ram_addr); end
    tick(); tick();
    tests++;
    if (cli.ack_b !== 1'b1 || cli.ack_a !== 1'b0 || cli.rdata_b !== 18'h12345) begin
      fails++; $display("FAIL tie_ack_b: ack=%b%b rdata_b=%h, want a=0 b=1 12345", cli.ack_a, cli.ack_b, cli.rdata_b);
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] order = '0;
    int nack = 0, bad = 0, extra = 0;
    set_req(0, 1'b1, 1'b0, 7'd5, '0);
    set_req(1, 1'b1, 1'b0, 7'd6, '0);
    for (int c = 1; c <= 40 && nack < 6; c++) begin
      tick();
      if (cli.ack_a && cli.ack_b) bad++;
      if (cli.ack_a || cli.ack_b) begin
        order[nack] = cli.ack_b;
        if (c != 3 * (nack + 1)) bad++;
        if (cli.ack_a && cli.rdata_a !== 18'h2AAAA) bad++;
        if (cli.ack_b && cli.rdata_b !== 18'h12345) bad++;
        nack++;
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    tests++;
    if (nack !== 6 || order !== 6'b101010) begin
      fails++; $display("FAIL rr_order: %0d acks order=%b, want 6 acks 101010", nack, order);
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL rr_timing: %0d bad acks, want 0", bad); end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cli.ack_a || cli.ack_b) extra++;
    end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL rr_drain: %0d extra acks, want 0", extra); end
  endtask

  task automatic test_reset_mid_clear();
    int nwr, bad, last_at, done_at, c;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c = 0;
    while (!(ram_we === 1'b1 && ram_addr === 7'd60) && c < 200) begin
      tick(); c++;
    end
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 7'd60) begin
      fails++; $display("FAIL midclr_reach: we=%b addr=%0d, want 1/60", ram_we, ram_addr);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (ram_we !== 1'b0 || ram_addr !== '0 || init_done !== 1'b0) begin
      fails++; $display("FAIL midclr_rst: we=%b addr=%0d init_done=%b, want 0/0/0", ram_we, ram_addr, init_done);
    end
    tick();
    reset = 1'b0;
    run_sweep(nwr, bad, last_at, done_at);
    tests++;
    if (nwr !== 128 || bad !== 0) begin
      fails++; $display("FAIL midclr_sweep: %0d writes %0d bad, want 128/0", nwr, bad);
    end
    tests++;
    if (done_at !== last_at + 1) begin
      fails++; $display("FAIL midclr_done_time: init_done at %0d, want %0d", done_at, last_at + 1);
    end
  endtask

  task automatic test_boundary();
    int nz = 0;
    logic [DW-1:0] v127 = '0;
    set_req(1, 1'b1, 1'b1, 7'd127, 18'h3FFFF);
    tick();
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 7'd127 || ram_wdata !== 18'h3FFFF) begin
      fails++; $display("FAIL bnd_wr_issue: we=%b addr=%0d wdata=%h, want 1/127/3ffff", ram_we, ram_addr, ram_wdata);
    end
    tick(); tick();
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    set_req(1, 1'b1, 1'b0, 7'd127, '0);
    tick(); tick(); tick();
    tests++;
    if (cli.ack_b !== 1'b1 || cli.rdata_b !== 18'h3FFFF) begin
      fails++; $display("FAIL bnd_rd_127: ack_b=%b rdata_b=%h, want 1/3ffff", cli.ack_b, cli.rdata_b);
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      addr2 = AW'(i);
      tick();
      if (i == DEPTH - 1) v127 = dout2;
      else if (dout2 !== '0) nz++;
    end
    tests++;
    if (v127 !== 18'h3FFFF) begin fails++; $display("FAIL port2_127: got %h, want 3ffff", v127); end
    tests++;
    if (nz !== 0) begin fails++; $display("FAIL port2_zero: %0d nonzero words, want 0", nz); end
  endtask

  task automatic test_reset_in_issue();
    int nwr, bad, last_at, done_at;
    set_req(0, 1'b1, 1'b0, 7'd127, '0);
    tick();
    tests++;
    if (ram_addr !== 7'd127 || ram_we !== 1'b0) begin
      fails++; $display("FAIL issue_reach: addr=%0d we=%b, want 127/0", ram_addr, ram_we);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (cli.ack_a !== 1'b0 || init_done !== 1'b0 || ram_addr !== '0) begin
      fails++; $display("FAIL issue_rst: ack_a=%b init_done=%b addr=%0d, want 0/0/0", cli.ack_a, init_done, ram_addr);
    end
    tick();
    reset = 1'b0;
    run_sweep(nwr, bad, last_at, done_at);
    tests++;
    if (nwr !== 128 || bad !== 0) begin
      fails++; $display("FAIL issue_resweep: %0d writes %0d bad, want 128/0", nwr, bad);
    end
    tick();
    tests++;
    if (ram_addr !== 7'd127 || ram_we !== 1'b0) begin
      fails++; $display("FAIL issue_regrant: addr=%0d we=%b, want 127/0", ram_addr, ram_we);
    end
    tick(); tick();
    tests++;
    if (cli.ack_a !== 1'b1 || cli.rdata_a !== '0) begin
      fails++; $display("FAIL issue_served: ack_a=%b rdata_a=%h, want 1/0", cli.ack_a, cli.rdata_a);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  initial begin
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_clear();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_reset_mid_clear();
    test_boundary();
    test_reset_in_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
